// File: rtl/addr_buff_pkg.sv
// Shared types and width helpers for the banked address-buffer read sequencer.
package addr_buff_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;

  localparam int FIFO_DEPTH = 2;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bank_w(input int bands);
    return (bands > 1) ? $clog2(bands) : 1;
  endfunction

endpackage

// File: rtl/addr_buff_out_fifo.sv
// Two-entry valid/ready output FIFO of {last, data}; the head entry drives the stream directly.
module addr_buff_out_fifo
  import addr_buff_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic                  pop,
  output logic [1:0]            count,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  logic [1:0]          count_q;
  logic [DATA_WIDTH:0] head_q;
  logic [DATA_WIDTH:0] tail_q;
  logic [DATA_WIDTH:0] in_word;

  assign in_word   = {push_last, push_data};
  assign m_valid_o = (count_q != 2'd0);
  assign pop       = m_valid_o && m_ready_i;
  assign count     = count_q;
  assign m_data_o  = head_q[DATA_WIDTH-1:0];
  assign m_last_o  = head_q[DATA_WIDTH];

  // Head entry is the stream output register; it only moves on a pop or a push into an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          count_q <= count_q + 2'd1;
          if (count_q == 2'd0) head_q <= in_word;
        end
        2'b01: begin
          count_q <= count_q - 2'd1;
          if (count_q == 2'd2) head_q <= tail_q;
        end
        2'b11: begin
          if (count_q == 2'd1) head_q <= in_word;
          else if (count_q == 2'd2) head_q <= tail_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((push && !pop && count_q == 2'd1) || (push && pop && count_q == 2'd2))
      tail_q <= in_word;
  end

endmodule

// File: rtl/address_buff_reader.sv
// Credit-controlled read sequencer draining the banked address buffer into a valid/ready stream.
// Define ADDR_BUFF_RD_INTERLEAVE_EN for address-major (bank-interleaved) read order.
module address_buff_reader
  import addr_buff_pkg::*;
#(
  parameter  int SRAM_DEPTH = 1024,
  parameter  int BAND_WIDTH = 16,
  parameter  int DATA_WIDTH = 10,
  localparam int AW         = addr_w(SRAM_DEPTH),
  localparam int BW         = bank_w(BAND_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BW:0]           bank_cnt_i,
  input  logic [AW:0]           bank_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  enb_o,
  output logic [AW+BW-1:0]      addrb_o,
  input  logic [DATA_WIDTH-1:0] dob_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  rd_state_t      state_q, state_d;
  logic [BW:0]    cnt_q, cnt_clamp;
  logic [AW:0]    len_q, len_clamp;
  logic [BW-1:0]  bank_q;
  logic [AW-1:0]  entry_q;
  logic           vld_p1, last_p1;
  logic [1:0]     fifo_count;
  logic           fifo_pop;
  logic           bank_last, entry_last, rd_last, credit, issue;

  assign cnt_clamp  = (bank_cnt_i > (BW+1)'(BAND_WIDTH)) ? (BW+1)'(BAND_WIDTH) : bank_cnt_i;
  assign len_clamp  = (bank_len_i > (AW+1)'(SRAM_DEPTH)) ? (AW+1)'(SRAM_DEPTH) : bank_len_i;
  assign bank_last  = ({1'b0, bank_q} == cnt_q - (BW+1)'(1));
  assign entry_last = ({1'b0, entry_q} == len_q - (AW+1)'(1));
  assign rd_last    = bank_last && entry_last;

  // A read issued now lands in the FIFO two edges later; only the read already returning is outstanding.
  assign credit  = ({1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, fifo_pop}) < 3'(FIFO_DEPTH);
  assign issue   = (state_q == READ) && credit;
  assign enb_o   = issue;
  assign addrb_o = {bank_q, entry_q};
  assign busy_o  = (state_q == READ) || (state_q == DRAIN);
  assign done_o  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = (cnt_clamp == '0 || len_clamp == '0) ? DONE : READ;
      READ:  if (issue && rd_last) state_d = DRAIN;
      DRAIN: if (fifo_pop && m_last_o) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      bank_q  <= '0;
      entry_q <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      last_p1 <= issue && rd_last;
      if (state_q == IDLE && start_i && state_d == READ) begin
        cnt_q   <= cnt_clamp;
        len_q   <= len_clamp;
        bank_q  <= '0;
        entry_q <= '0;
      end else if (issue && !rd_last) begin
`ifdef ADDR_BUFF_RD_INTERLEAVE_EN
        if (bank_last) begin
          bank_q  <= '0;
          entry_q <= entry_q + 1'b1;
        end else begin
          bank_q  <= bank_q + 1'b1;
        end
`else
        if (entry_last) begin
          entry_q <= '0;
          bank_q  <= bank_q + 1'b1;
        end else begin
          entry_q <= entry_q + 1'b1;
        end
`endif
      end
    end
  end

  // ---- p1: returning read data enters the output FIFO ----
  addr_buff_out_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (dob_i),
    .push_last (last_p1),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o)
  );

endmodule

// File: tb/tb_address_buff_reader.sv
// Randomized self-checking bench for address_buff_reader against a queue-based drain model.
module tb_address_buff_reader;

  localparam int SRAM_DEPTH = 1024;
  localparam int BAND_WIDTH = 16;
  localparam int DATA_WIDTH = 10;
  localparam int AW = 10;
  localparam int BW = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic [BW:0]           bank_cnt_i = '0;
  logic [AW:0]           bank_len_i = '0;
  logic                  busy_o, done_o, enb_o;
  logic [AW+BW-1:0]      addrb_o;
  logic [DATA_WIDTH-1:0] dob_i = '0;
  logic                  m_valid_o;
  logic                  m_ready_i = 1'b0;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;

  logic [DATA_WIDTH-1:0] mem [0:BAND_WIDTH*SRAM_DEPTH-1];

  int checks = 0;
  int failures = 0;

  address_buff_reader #(
    .SRAM_DEPTH(SRAM_DEPTH), .BAND_WIDTH(BAND_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bank_cnt_i(bank_cnt_i), .bank_len_i(bank_len_i),
    .busy_o(busy_o), .done_o(done_o), .enb_o(enb_o), .addrb_o(addrb_o), .dob_i(dob_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o)
  );

  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) dob_i <= enb_o ? mem[addrb_o] : DATA_WIDTH'($urandom);

  task automatic fill_pattern();
    for (int a = 0; a < BAND_WIDTH*SRAM_DEPTH; a++)
      mem[a] = DATA_WIDTH'((a / SRAM_DEPTH) * 16 + (a % SRAM_DEPTH));
  endtask

  task automatic fill_random();
    for (int a = 0; a < BAND_WIDTH*SRAM_DEPTH; a++) mem[a] = DATA_WIDTH'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, enb_o, m_valid_o, m_last_o} !== 5'b0 || addrb_o !== '0 || m_data_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ctl=%b addr=%0h data=%0h required all zero",
               {busy_o, done_o, enb_o, m_valid_o, m_last_o}, addrb_o, m_data_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: ready high; 1: ready low for 10 cycles from the first valid; 2: random ready.
  task automatic run_drain(input int cnt, input int len, input int mode, input bit poke_start);
    int exp_addr[$];
    int ecnt, elen, n, issued, accepted, cyc, first_enb, first_vld, first_hs, last_hs, bound;
    bit done_seen, prev_stall, prev_last;
    logic [DATA_WIDTH-1:0] prev_data;
    ecnt = (cnt > BAND_WIDTH) ? BAND_WIDTH : cnt;
    elen = (len > SRAM_DEPTH) ? SRAM_DEPTH : len;
`ifdef ADDR_BUFF_RD_INTERLEAVE_EN
    for (int e = 0; e < elen; e++)
      for (int b = 0; b < ecnt; b++) exp_addr.push_back(b * SRAM_DEPTH + e);
`else
    for (int b = 0; b < ecnt; b++)
      for (int e = 0; e < elen; e++) exp_addr.push_back(b * SRAM_DEPTH + e);
`endif
    n = exp_addr.size();
    issued = 0; accepted = 0; first_enb = -1; first_vld = -1; first_hs = -1; last_hs = -1;
    done_seen = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    bound = n * 8 + 100;
    @(negedge clk);
    start_i = 1'b1; bank_cnt_i = (BW+1)'(cnt); bank_len_i = (AW+1)'(len); m_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < bound) begin
      case (mode)
        0: m_ready_i = 1'b1;
        1: m_ready_i = !(cyc >= 3 && cyc < 13);
        default: m_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      start_i = poke_start && (cyc == 100);
      #1;
      if (prev_stall) begin
        checks++;
        if (!m_valid_o || m_data_o !== prev_data || m_last_o !== prev_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%b d=%0h l=%b required v=1 d=%0h l=%b",
                   m_valid_o, m_data_o, m_last_o, prev_data, prev_last);
        end
      end
      if (enb_o) begin
        if (first_enb < 0) first_enb = cyc;
        checks++;
        if (issued >= n) begin
          failures++;
          $display("FAIL extra_read: got read %0d at addr %0h required only %0d reads", issued, addrb_o, n);
        end else if (int'(addrb_o) != exp_addr[issued]) begin
          failures++;
          $display("FAIL read_addr: got %0h required %0h (read %0d)", addrb_o, exp_addr[issued], issued);
        end
        issued++;
      end
      if (m_valid_o && first_vld < 0) first_vld = cyc;
      if (m_valid_o && m_ready_i) begin
        checks++;
        if (accepted >= n) begin
          failures++;
          $display("FAIL extra_beat: got beat %0d required only %0d", accepted, n);
        end else if (m_data_o !== mem[exp_addr[accepted]] || m_last_o !== (accepted == n - 1)) begin
          failures++;
          $display("FAIL beat: got d=%0h l=%b required d=%0h l=%b (beat %0d)", m_data_o, m_last_o,
                   mem[exp_addr[accepted]], (accepted == n - 1), accepted);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        accepted++;
      end
      checks++;
      if (issued - accepted > 2) begin
        failures++;
        $display("FAIL credit: got %0d words outstanding required at most 2", issued - accepted);
      end
      checks++;
      if (busy_o !== !done_o) begin
        failures++;
        $display("FAIL busy: got busy=%b done=%b required busy=%b", busy_o, done_o, !done_o);
      end
      if (done_o) begin
        done_seen = 1;
        checks++;
        if (cyc != last_hs + 1 || accepted != n || issued != n) begin
          failures++;
          $display("FAIL done_timing: got cyc=%0d beats=%0d reads=%0d required cyc=%0d beats=reads=%0d",
                   cyc, accepted, issued, last_hs + 1, n);
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL drain_timeout: got %0d beats after %0d cycles required %0d and done", accepted, cyc, n);
    end
    checks++;
    if (first_enb != 1 || first_vld != 3) begin
      failures++;
      $display("FAIL first_beat: got enb at %0d valid at %0d required 1 and 3", first_enb, first_vld);
    end
    if (mode == 0) begin
      checks++;
      if (last_hs - first_hs != n - 1) begin
        failures++;
        $display("FAIL throughput: got %0d cycles for %0d beats required %0d", last_hs - first_hs + 1, n, n);
      end
    end
  endtask

  task automatic test_empty(input int cnt, input int len);
    int dones, first_done;
    bit bad;
    dones = 0; first_done = -1; bad = 0;
    @(negedge clk);
    start_i = 1'b1; bank_cnt_i = (BW+1)'(cnt); bank_len_i = (AW+1)'(len); m_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (enb_o || m_valid_o) bad = 1;
      if (done_o) begin dones++; if (first_done < 0) first_done = c; end
      @(negedge clk);
    end
    checks++;
    if (bad || dones != 1 || first_done < 1 || first_done > 2) begin
      failures++;
      $display("FAIL empty_start: got activity=%b dones=%0d at %0d required no reads, one done within 2 cycles",
               bad, dones, first_done);
    end
  endtask

  task automatic test_reset_mid_drain();
    int dones;
    dones = 0;
    @(negedge clk);
    start_i = 1'b1; bank_cnt_i = 5'd2; bank_len_i = 11'd3; m_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, enb_o, m_valid_o, m_last_o} !== 5'b0 || addrb_o !== '0 || m_data_o !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got ctl=%b addr=%0h data=%0h required all zero",
               {busy_o, done_o, enb_o, m_valid_o, m_last_o}, addrb_o, m_data_o);
    end
    for (int c = 0; c < 5; c++) begin
      if (done_o || m_valid_o) dones++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", dones);
    end
    run_drain(1, 2, 0, 0);
  endtask

  initial begin
    fill_pattern();
    test_reset();
    run_drain(2, 3, 0, 0);
    run_drain(2, 3, 1, 0);
    test_empty(0, 3);
    test_empty(2, 0);
    run_drain(31, 3, 2, 0);
    run_drain(1, 2047, 0, 0);
    test_reset_mid_drain();
    fill_random();
    run_drain(16, 1024, 2, 1);
    run_drain($urandom_range(1, 5), $urandom_range(1, 40), 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
